// File: rtl/bpred_mem_bank_if.sv
// rtl/bpred_mem_bank_if.sv - fetch-side bus of the branch predictor storage bank
// Groups the instruction memory and weight table write/read ports behind master/slave views.
interface bpred_mem_bank_if #(
  parameter int INSN_AW = 8,
  parameter int INSN_DW = 32,
  parameter int TBL_AW  = 6,
  parameter int GHR     = 12,
  parameter int HOB     = 3,
  parameter int LOB     = 5
);
  logic                 insn_wren;
  logic [INSN_AW-1:0]   insn_waddr;
  logic [INSN_DW-1:0]   insn_wdata;
  logic [INSN_AW-1:0]   insn_raddr;
  logic [INSN_DW-1:0]   insn_q;

  logic                 tbl_wren;
  logic [TBL_AW-1:0]    tbl_waddr;
  logic [TBL_AW-1:0]    tbl_raddr;
  logic [HOB*GHR-1:0]   hob_wdata;
  logic [HOB*GHR-1:0]   hobc_wdata;
  logic [LOB*GHR-1:0]   lob_wdata;
  logic [HOB*GHR-1:0]   hob_q;
  logic [HOB*GHR-1:0]   hobc_q;
  logic [LOB*GHR-1:0]   lob_q;

  logic                 init_busy;

  modport master (
    output insn_wren, insn_waddr, insn_wdata, insn_raddr,
    output tbl_wren, tbl_waddr, tbl_raddr, hob_wdata, hobc_wdata, lob_wdata,
    input  insn_q, hob_q, hobc_q, lob_q, init_busy
  );

  modport slave (
    input  insn_wren, insn_waddr, insn_wdata, insn_raddr,
    input  tbl_wren, tbl_waddr, tbl_raddr, hob_wdata, hobc_wdata, lob_wdata,
    output insn_q, hob_q, hobc_q, lob_q, init_busy
  );
endinterface

// File: rtl/bpred_mem_bank.sv
// rtl/bpred_mem_bank.sv - instruction memory and perceptron weight tables for fetch
// Simple dual-port memories with registered reads and a post-reset zeroing sweep of the tables.
module bpred_mem_bank #(
  parameter int INSN_AW = 8,
  parameter int INSN_DW = 32,
  parameter int TBL_AW  = 6,
  parameter int GHR     = 12,
  parameter int HOB     = 3,
  parameter int LOB     = 5
) (
  input  logic              clk,
  input  logic              reset,
  bpred_mem_bank_if.slave   bus
);

  localparam int INSN_DEPTH = 1 << INSN_AW;
  localparam int TBL_DEPTH  = 1 << TBL_AW;
  localparam int HW         = HOB * GHR;
  localparam int LW         = LOB * GHR;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [TBL_AW-1:0]   cnt_q;
  logic [TBL_AW-1:0]   cnt_d;
  logic                sweep;

  logic [INSN_DW-1:0]  insn_mem [INSN_DEPTH];
  logic [HW-1:0]       hob_mem  [TBL_DEPTH];
  logic [HW-1:0]       hobc_mem [TBL_DEPTH];
  logic [LW-1:0]       lob_mem  [TBL_DEPTH];

  logic                wr_allow;
  logic                insn_we;
  logic                tbl_we;
  logic [TBL_AW-1:0]   tbl_wa;
  logic [HW-1:0]       hob_wd;
  logic [HW-1:0]       hobc_wd;
  logic [LW-1:0]       lob_wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter parks at the last index rather than wrapping once the sweep ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep   = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        sweep = 1'b1;
        if (cnt_q == {TBL_AW{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TBL_AW'(1);
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_SWEEP;
      end
    endcase
  end

  assign bus.init_busy = sweep;

  // Writes are blocked while reset is held so instruction contents survive it.
  assign wr_allow = reset;
  assign insn_we  = wr_allow & bus.insn_wren;
  assign tbl_we   = wr_allow & (sweep | bus.tbl_wren);
  assign tbl_wa   = sweep ? cnt_q : bus.tbl_waddr;
  assign hob_wd   = sweep ? '0 : bus.hob_wdata;
  assign hobc_wd  = sweep ? '0 : bus.hobc_wdata;
  assign lob_wd   = sweep ? '0 : bus.lob_wdata;

  always_ff @(posedge clk) begin
    if (insn_we) begin
      insn_mem[bus.insn_waddr] <= bus.insn_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      hob_mem[tbl_wa]  <= hob_wd;
      hobc_mem[tbl_wa] <= hobc_wd;
      lob_mem[tbl_wa]  <= lob_wd;
    end
  end

  // Registered reads sample the array before this edge's write lands: old data on collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.insn_q <= '0;
    end else begin
      bus.insn_q <= insn_mem[bus.insn_raddr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.hob_q  <= '0;
      bus.hobc_q <= '0;
      bus.lob_q  <= '0;
    end else begin
      bus.hob_q  <= hob_mem[bus.tbl_raddr];
      bus.hobc_q <= hobc_mem[bus.tbl_raddr];
      bus.lob_q  <= lob_mem[bus.tbl_raddr];
    end
  end

endmodule

// File: tb/tb_bpred_mem_bank.sv
// tb/tb_bpred_mem_bank.sv - self-checking bench for the predictor storage bank
// Directed vector table, reset/sweep sequences and random traffic against a memory model.
module tb_bpred_mem_bank;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bpred_mem_bank_if bus ();

  bpred_mem_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_insn [256];
  logic [35:0] m_hob  [64];
  logic [35:0] m_hobc [64];
  logic [59:0] m_lob  [64];
  int          m_edges;
  logic [31:0] e_insn;
  logic [35:0] e_hob;
  logic [35:0] e_hobc;
  logic [59:0] e_lob;

  typedef struct {
    logic        iw;
    logic [7:0]  iwa;
    logic [31:0] iwd;
    logic [7:0]  ira;
    logic        tw;
    logic [5:0]  twa;
    logic [5:0]  tra;
    logic [35:0] hw;
    logic [35:0] hcw;
    logic [59:0] lw;
    logic [31:0] x_insn;
    logic [35:0] x_hob;
    logic [35:0] x_hobc;
    logic [59:0] x_lob;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: reads return the array as it was before this edge, then writes land;
  // for 64 edges after reset release entry n is cleared on edge n and external table writes are lost.
  task automatic model_edge();
    if (!reset) begin
      e_insn = '0; e_hob = '0; e_hobc = '0; e_lob = '0;
      m_edges = 0;
    end else begin
      e_insn = m_insn[bus.insn_raddr];
      e_hob  = m_hob[bus.tbl_raddr];
      e_hobc = m_hobc[bus.tbl_raddr];
      e_lob  = m_lob[bus.tbl_raddr];
      if (bus.insn_wren) m_insn[bus.insn_waddr] = bus.insn_wdata;
      if (m_edges < 64) begin
        m_hob[m_edges] = '0; m_hobc[m_edges] = '0; m_lob[m_edges] = '0;
        m_edges++;
      end else if (bus.tbl_wren) begin
        m_hob[bus.tbl_waddr]  = bus.hob_wdata;
        m_hobc[bus.tbl_waddr] = bus.hobc_wdata;
        m_lob[bus.tbl_waddr]  = bus.lob_wdata;
      end
    end
  endtask

  task automatic check_model();
    chk("model insn_q", 64'(bus.insn_q), 64'(e_insn));
    chk("model hob_q", 64'(bus.hob_q), 64'(e_hob));
    chk("model hobc_q", 64'(bus.hobc_q), 64'(e_hobc));
    chk("model lob_q", 64'(bus.lob_q), 64'(e_lob));
    chk("model init_busy", 64'(bus.init_busy), 64'(m_edges < 64));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    bus.insn_wren = 1'b0; bus.insn_waddr = '0; bus.insn_wdata = '0; bus.insn_raddr = '0;
    bus.tbl_wren = 1'b0; bus.tbl_waddr = '0; bus.tbl_raddr = '0;
    bus.hob_wdata = '0; bus.hobc_wdata = '0; bus.lob_wdata = '0;
  endtask

  // Pull reset low away from any edge and confirm outputs react without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, " insn_q"}, 64'(bus.insn_q), 64'd0);
    chk({tag, " hob_q"}, 64'(bus.hob_q), 64'd0);
    chk({tag, " hobc_q"}, 64'(bus.hobc_q), 64'd0);
    chk({tag, " lob_q"}, 64'(bus.lob_q), 64'd0);
    chk({tag, " init_busy"}, 64'(bus.init_busy), 64'd1);
    m_edges = 0;
    e_insn = '0; e_hob = '0; e_hobc = '0; e_lob = '0;
  endtask

  task automatic run_sweep(input string tag, input bit with_traffic);
    int n = 0;
    logic [63:0] r;
    do begin
      idle_inputs();
      if (with_traffic) begin
        bus.insn_wren  = 1'b1;
        bus.insn_waddr = 8'(n);
        bus.insn_wdata = 32'hA000_0000 + 32'(n);
        bus.tbl_raddr  = 6'(n);
        bus.tbl_wren   = (n == 10);
        bus.tbl_waddr  = 6'd7;
        bus.hob_wdata  = '1; bus.hobc_wdata = '1; bus.lob_wdata = '1;
      end else begin
        r = {$urandom, $urandom};
        bus.tbl_wren   = 1'b1;
        bus.tbl_waddr  = r[5:0];
        bus.tbl_raddr  = r[11:6];
        bus.hob_wdata  = r[35:0]; bus.hobc_wdata = r[63:28]; bus.lob_wdata = {r[59:0]};
      end
      tick();
      n++;
    end while (bus.init_busy && n < 100);
    chk({tag, " sweep length"}, 64'(n), 64'd64);
  endtask

  task automatic read_all_tables(input string tag);
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      bus.tbl_raddr  = 6'(i);
      bus.insn_raddr = 8'(i);
      tick();
      chk({tag, " hob zero"}, 64'(bus.hob_q), 64'd0);
      chk({tag, " hobc zero"}, 64'(bus.hobc_q), 64'd0);
      chk({tag, " lob zero"}, 64'(bus.lob_q), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [35:0] h5, hc5, h6, hc6;
    logic [59:0] l5, l6;
    logic [63:0] r0, r1, r2;
    h5 = 36'h123456789; hc5 = 36'hEDCBA9876; l5 = 60'h0FEDCBA98765432;
    h6 = 36'h0F0F0F0F0; hc6 = 36'h5A5A5A5A5; l6 = 60'h111122223333444;

    for (int i = 0; i < 256; i++) m_insn[i] = '0;
    for (int i = 0; i < 64; i++) begin
      m_hob[i] = '0; m_hobc[i] = '0; m_lob[i] = '0;
    end
    idle_inputs();

    async_reset("por");
    tick();
    tick();
    reset = 1'b1;
    run_sweep("first", 1'b1);

    bus.insn_wren = 1'b1;
    read_all_tables("first");

    vt[0] = '{1'b0, 8'h00, 32'h0, 8'h00, 1'b1, 6'd5, 6'd5, h5, hc5, l5, 32'hA000_0000, 36'h0, 36'h0, 60'h0};
    vt[1] = '{1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 6'd0, 6'd5, 36'h0, 36'h0, 60'h0, 32'hA000_0000, h5, hc5, l5};
    vt[2] = '{1'b1, 8'hFF, 32'hDEADBEEF, 8'hFF, 1'b0, 6'd0, 6'd5, 36'h0, 36'h0, 60'h0, 32'h0, h5, hc5, l5};
    vt[3] = '{1'b0, 8'h00, 32'h0, 8'hFF, 1'b0, 6'd0, 6'd7, 36'h0, 36'h0, 60'h0, 32'hDEADBEEF, 36'h0, 36'h0, 60'h0};
    vt[4] = '{1'b0, 8'h00, 32'h0, 8'h01, 1'b0, 6'd0, 6'd5, 36'h0, 36'h0, 60'h0, 32'hA000_0001, h5, hc5, l5};
    vt[5] = '{1'b0, 8'h00, 32'h0, 8'h02, 1'b0, 6'd0, 6'd6, 36'h0, 36'h0, 60'h0, 32'hA000_0002, 36'h0, 36'h0, 60'h0};
    vt[6] = '{1'b0, 8'h00, 32'h0, 8'h03, 1'b0, 6'd0, 6'd5, 36'h0, 36'h0, 60'h0, 32'hA000_0003, h5, hc5, l5};
    vt[7] = '{1'b1, 8'h0A, 32'h12345678, 8'h0A, 1'b1, 6'd6, 6'd6, h6, hc6, l6, 32'hA000_000A, 36'h0, 36'h0, 60'h0};
    vt[8] = '{1'b0, 8'h00, 32'h0, 8'h0A, 1'b0, 6'd0, 6'd6, 36'h0, 36'h0, 60'h0, 32'h12345678, h6, hc6, l6};

    // The bench writes 0 to 8'hFF first so the read-during-write row does not lean on power-up state.
    idle_inputs();
    bus.insn_wren = 1'b1; bus.insn_waddr = 8'hFF; bus.insn_wdata = 32'h0;
    tick();

    for (int i = 0; i < 9; i++) begin
      bus.insn_wren = vt[i].iw; bus.insn_waddr = vt[i].iwa; bus.insn_wdata = vt[i].iwd;
      bus.insn_raddr = vt[i].ira;
      bus.tbl_wren = vt[i].tw; bus.tbl_waddr = vt[i].twa; bus.tbl_raddr = vt[i].tra;
      bus.hob_wdata = vt[i].hw; bus.hobc_wdata = vt[i].hcw; bus.lob_wdata = vt[i].lw;
      tick();
      chk($sformatf("vec%0d insn_q", i), 64'(bus.insn_q), 64'(vt[i].x_insn));
      chk($sformatf("vec%0d hob_q", i), 64'(bus.hob_q), 64'(vt[i].x_hob));
      chk($sformatf("vec%0d hobc_q", i), 64'(bus.hobc_q), 64'(vt[i].x_hobc));
      chk($sformatf("vec%0d lob_q", i), 64'(bus.lob_q), 64'(vt[i].x_lob));
      chk($sformatf("vec%0d init_busy", i), 64'(bus.init_busy), 64'd0);
    end

    // Random traffic, narrow address ranges so read/write collisions are frequent.
    for (int i = 0; i < 400; i++) begin
      r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
      bus.insn_wren  = r0[0];
      bus.insn_waddr = {4'h8, r0[4:1]};
      bus.insn_raddr = {4'h8, r0[8:5]};
      bus.insn_wdata = r1[63:32];
      bus.tbl_wren   = r0[9];
      bus.tbl_waddr  = {3'b000, r0[12:10]};
      bus.tbl_raddr  = {3'b000, r0[15:13]};
      bus.hob_wdata  = r1[35:0];
      bus.hobc_wdata = r2[35:0];
      bus.lob_wdata  = {r2[63:36], r0[63:32]};
      tick();
    end

    idle_inputs();
    async_reset("mid");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.tbl_raddr = 6'(i);
      tick();
    end
    async_reset("restart");
    tick();
    reset = 1'b1;
    run_sweep("restart", 1'b0);
    read_all_tables("restart");

    idle_inputs();
    bus.insn_raddr = 8'hFF;
    tick();
    chk("kept insn FF", 64'(bus.insn_q), 64'h0000_0000_DEAD_BEEF);
    bus.insn_raddr = 8'h03;
    tick();
    chk("kept insn 03", 64'(bus.insn_q), 64'h0000_0000_A000_0003);
    for (int i = 128; i < 144; i++) begin
      bus.insn_raddr = 8'(i);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
